// File: rtl/bus_master_pkg.sv
// bus_master_pkg: shared types and defaults for the trans/ready bus initiator.
// Imported by bus_master, bus_master_wdog and the bench.
package bus_master_pkg;

    localparam int unsigned DefAddrW = 32;
    localparam int unsigned DefDataW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } master_state_e;

    // A completed transfer as seen on the response stream
    typedef struct packed {
        logic [DefDataW-1:0] rdata;
        logic                err;
    } bus_rsp_t;

endpackage

// File: rtl/bus_master_wdog.sv
// bus_master_wdog: REQ-phase watchdog, built only when BUS_MASTER_TIMEOUT_EN is defined.
// expired_o is high during the REQ cycle whose closing edge is the TIMEOUT-th one.
module bus_master_wdog
    import bus_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rstz,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] count_q;

    // The counter holds the number of REQ edges already elapsed, so the
    // abort edge is the one where count_q still equals TIMEOUT-1.
    assign expired_o = enable_i && (count_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && !expired_o) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/bus_master.sv
// bus_master: single-outstanding initiator turning a valid/ready command stream into
// trans/ready bus transfers. Optional REQ timeout abort under BUS_MASTER_TIMEOUT_EN.
module bus_master
    import bus_master_pkg::*;
#(
    parameter int unsigned ADDR_W  = DefAddrW,
    parameter int unsigned DATA_W  = DefDataW,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rstz,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              trans,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic              ready
);

    master_state_e     state_q;
    logic              cmdReady_q;
    logic              trans_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rspValid_q;
    logic [DATA_W-1:0] rspRdata_q;
    logic              rspErr_q;

    logic              cmdAccept;
    logic              timeoutHit;
    logic [ADDR_W-1:0] alignedAddr;
    logic [DATA_W-1:0] rspRdata_d;

    assign cmdAccept   = (state_q == IDLE) && cmd_valid && cmdReady_q;
    assign alignedAddr = cmd_addr & ~ADDR_W'(3);
    assign rspRdata_d  = write_q ? '0 : rdata;

`ifdef BUS_MASTER_TIMEOUT_EN
    bus_master_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .rstz      (rstz),
        .clear_i   (cmdAccept),
        .enable_i  (state_q == REQ),
        .expired_o (timeoutHit)
    );
`else
    assign timeoutHit = 1'b0;
`endif

    // cmd_ready is a register so it stays low throughout reset and rises on
    // the first edge after release; ready is compared with === so X/Z never
    // completes a transfer.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q    <= IDLE;
            cmdReady_q <= 1'b0;
            trans_q    <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rspValid_q <= 1'b0;
            rspRdata_q <= '0;
            rspErr_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cmdReady_q <= 1'b1;
                    if (cmdAccept) begin
                        write_q    <= cmd_write;
                        addr_q     <= alignedAddr;
                        wdata_q    <= cmd_wdata;
                        trans_q    <= 1'b1;
                        cmdReady_q <= 1'b0;
                        state_q    <= REQ;
                    end
                end
                REQ: begin
                    if (ready === 1'b1) begin
                        trans_q    <= 1'b0;
                        rspRdata_q <= rspRdata_d;
                        rspErr_q   <= 1'b0;
                        rspValid_q <= 1'b1;
                        state_q    <= RESP;
                    end else if (timeoutHit) begin
                        trans_q    <= 1'b0;
                        rspRdata_q <= '0;
                        rspErr_q   <= 1'b1;
                        rspValid_q <= 1'b1;
                        state_q    <= RESP;
                    end
                end
                RESP: begin
                    if (rspValid_q && rsp_ready) begin
                        rspValid_q <= 1'b0;
                        cmdReady_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmdReady_q;
    assign trans     = trans_q;
    assign write     = write_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign rsp_valid = rspValid_q;
    assign rsp_rdata = rspRdata_q;
    assign rsp_err   = rspErr_q;

endmodule

// File: tb/tb_bus_master.sv
// tb_bus_master: directed and randomized bench for bus_master with a behavioural slave
// and a word-addressed reference memory. Covers the timeout path when BUS_MASTER_TIMEOUT_EN is defined.
module tb_bus_master;
    import bus_master_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rstz = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              trans;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata = 'x;
    logic              ready = 1'b0;

    bus_master #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rstz      (rstz),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .trans     (trans),
        .write     (write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cycle = 0;

    always @(posedge clk) cycle++;

    // Every comparison in the bench funnels through here
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Contents of a never-written word, known to both slave and reference model
    function automatic logic [31:0] defaultWord(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // ---------------- behavioural slave ----------------
    int          slaveWaitSel = 0;
    logic [31:0] slaveMem [logic [31:0]];
    logic [31:0] lastBusAddr = '0;

    initial begin
        bit          busy;
        int          waitLeft;
        bit          capWrite;
        logic [31:0] capAddr;
        logic [31:0] capWdata;
        bit          fire;
        logic        sTrans;
        logic        sReady;
        logic        sRst;
        busy = 0;
        waitLeft = 0;
        capWrite = 0;
        capAddr = '0;
        capWdata = '0;
        forever begin
            @(posedge clk);
            sTrans = trans;
            sReady = ready;
            sRst   = rstz;
            fire   = 0;
            if (!sRst) begin
                busy = 0;
            end else if (sReady === 1'b1) begin
                busy = 0;
            end else if (busy) begin
                if (sTrans !== 1'b1) begin
                    busy = 0;
                end else begin
                    checkOutput("bus_write_stable", write, capWrite);
                    checkOutput("bus_addr_stable", addr, capAddr);
                    checkOutput("bus_wdata_stable", wdata, capWdata);
                    if (waitLeft > 0) begin
                        waitLeft--;
                        if (waitLeft == 0) begin
                            fire = 1;
                            busy = 0;
                        end
                    end
                end
            end else if (sTrans === 1'b1) begin
                capWrite    = write;
                capAddr     = addr;
                capWdata    = wdata;
                lastBusAddr = addr;
                waitLeft    = slaveWaitSel;
                if (waitLeft == 0) fire = 1;
                else busy = 1;
            end
            #1;
            if (fire) begin
                ready = 1'b1;
                if (capWrite) begin
                    slaveMem[capAddr] = capWdata;
                    rdata = 'x;
                end else begin
                    rdata = slaveMem.exists(capAddr) ? slaveMem[capAddr] : defaultWord(capAddr);
                end
            end else begin
                ready = (busy && ($urandom_range(0, 3) == 0)) ? 1'bx : 1'b0;
                rdata = 'x;
            end
        end
    end

    // ---------------- trans idle-gap monitor ----------------
    initial begin
        int lowRun;
        bit seenHigh;
        bit prevTrans;
        lowRun = 0;
        seenHigh = 0;
        prevTrans = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rstz) begin
                lowRun = 0;
                seenHigh = 0;
                prevTrans = 0;
            end else begin
                if (trans && !prevTrans && seenHigh) checkOutput("trans_gap_ge2", lowRun >= 2, 1);
                if (trans) begin
                    seenHigh = 1;
                    lowRun = 0;
                end else begin
                    lowRun++;
                end
                prevTrans = trans;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] refMem [logic [31:0]];

    // One complete command/response; waitSel<0 means the slave never answers
    task automatic applyStimulus(input bit isWrite, input logic [31:0] a, input logic [31:0] d,
                                 input int waitSel, input int holdCycles, output int acceptCycle);
        bus_rsp_t    exp;
        logic [31:0] wordAddr;
        int          budget;
        int          lat;
        int          expLat;
        wordAddr = a & ~32'h3;
        exp.err   = 1'b0;
        exp.rdata = isWrite ? 32'h0 : (refMem.exists(wordAddr) ? refMem[wordAddr] : defaultWord(wordAddr));
        expLat    = 2 + waitSel;
        if (waitSel < 0) begin
            exp.err   = 1'b1;
            exp.rdata = 32'h0;
            expLat    = TIMEOUT;
        end else if (isWrite) begin
            refMem[wordAddr] = d;
        end

        slaveWaitSel = waitSel;
        cmd_write = isWrite;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        budget = 0;
        while (cmd_ready !== 1'b1 && budget < 20) begin
            @(posedge clk);
            #1;
            budget++;
        end
        checkOutput("cmd_ready_wait", budget < 20, 1);
        @(posedge clk);
        #1;
        acceptCycle = cycle;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        checkOutput("trans_after_accept", trans, 1);
        checkOutput("cmd_ready_busy", cmd_ready, 0);

        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("rsp_latency", lat, expLat);
        checkOutput("rsp_rdata", rsp_rdata, exp.rdata);
        checkOutput("rsp_err", rsp_err, exp.err);
        checkOutput("bus_addr_aligned", lastBusAddr, wordAddr);
        checkOutput("trans_low_resp", trans, 0);

        if (holdCycles > 0) begin
            rsp_ready = 1'b0;
            repeat (holdCycles) begin
                @(posedge clk);
                #1;
                checkOutput("stall_rsp_valid", rsp_valid, 1);
                checkOutput("stall_rsp_rdata", rsp_rdata, exp.rdata);
                checkOutput("stall_cmd_ready", cmd_ready, 0);
                checkOutput("stall_trans", trans, 0);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rsp_consumed", rsp_valid, 0);
        slaveWaitSel = 0;
    endtask

    task automatic checkResetValues(input string phase);
        checkOutput({phase, "_trans"}, trans, 0);
        checkOutput({phase, "_write"}, write, 0);
        checkOutput({phase, "_addr"}, addr, 0);
        checkOutput({phase, "_wdata"}, wdata, 0);
        checkOutput({phase, "_rsp_valid"}, rsp_valid, 0);
        checkOutput({phase, "_rsp_rdata"}, rsp_rdata, 0);
        checkOutput({phase, "_rsp_err"}, rsp_err, 0);
        checkOutput({phase, "_cmd_ready"}, cmd_ready, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int t0;
        int t1;
        int tDummy;
        int budget;

        // Power-on reset
        #1;
        checkResetValues("por");
        #16;
        rstz = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("cmd_ready_after_release", cmd_ready, 1);

        // Write then read back, zero wait, back-to-back
        applyStimulus(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 0, 0, t0);
        applyStimulus(1'b0, 32'h0000_1000, 32'h0, 0, 0, t1);
        checkOutput("back_to_back_period", t1 - t0, 4);

        // Unaligned read address is word aligned on the bus
        applyStimulus(1'b1, 32'h0000_2000, 32'hA5A5_0F0F, 1, 0, tDummy);
        applyStimulus(1'b0, 32'h0000_2003, 32'h0, 0, 0, tDummy);

        // Response stalled for 10 cycles
        applyStimulus(1'b0, 32'h0000_1000, 32'h0, 2, 10, tDummy);

        // Randomized traffic with 0..3 slave wait states
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 32'h0000_3000 + 32'($urandom_range(0, 63)),
                          $urandom, $urandom_range(0, 3), 0, tDummy);
        end

        // Reset asserted while a transfer sits in REQ
        slaveWaitSel = -1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_4000;
        cmd_wdata = 32'h1234_5678;
        cmd_valid = 1'b1;
        budget = 0;
        while (cmd_ready !== 1'b1 && budget < 20) begin
            @(posedge clk);
            #1;
            budget++;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checkOutput("pre_reset_trans", trans, 1);
        #2;
        rstz = 1'b0;
        #1;
        checkResetValues("midreset");
        repeat (2) @(posedge clk);
        #2;
        rstz = 1'b1;
        slaveWaitSel = 0;
        @(posedge clk);
        #1;
        checkOutput("midreset_cmd_ready_release", cmd_ready, 1);
        repeat (5) begin
            @(posedge clk);
            #1;
            checkOutput("midreset_no_rsp", rsp_valid, 0);
            checkOutput("midreset_no_trans", trans, 0);
        end

`ifdef BUS_MASTER_TIMEOUT_EN
        // Slave never answers: abort with error after TIMEOUT cycles
        applyStimulus(1'b0, 32'h0000_5000, 32'h0, -1, 0, tDummy);
        applyStimulus(1'b1, 32'h0000_5000, 32'hCAFE_F00D, 0, 0, tDummy);
        applyStimulus(1'b0, 32'h0000_5000, 32'h0, 3, 0, tDummy);
`else
        applyStimulus(1'b0, 32'h0000_4000, 32'h0, 3, 0, tDummy);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_master.md
# bus_master

Synthesizable initiator for the single-outstanding trans/ready memory bus, driving the same signals a bus slave model responds to (trans, write, addr, wdata in; rdata, ready back). It converts a valid/ready command stream from an upstream engine or test sequencer into one bus transfer at a time, and returns read data or an error on a valid/ready response stream. It sits between on-chip requesters and any bus slave, memory model or RTL.

## Interface
- ADDR_W, 32, bus address width
- DATA_W, 32, bus data width
- TIMEOUT, 16, cycles in REQ without ready before abort (only with the timeout feature)
- clk  input  1  bus clock, all logic on posedge
- rstz  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted this cycle when high with cmd_valid
- cmd_write  input  1  1=write, 0=read
- cmd_addr  input  ADDR_W  byte address
- cmd_wdata  input  DATA_W  write data
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed
- rsp_rdata  output  DATA_W  read data (0 for writes and errors)
- rsp_err  output  1  transfer aborted by timeout
- trans  output  1  bus transfer request
- write  output  1  bus direction
- addr  output  ADDR_W  bus address, word aligned
- wdata  output  DATA_W  bus write data
- rdata  input  DATA_W  bus read data, valid when ready=1
- ready  input  1  slave completion, one-cycle pulse

## Operation
- States: IDLE, REQ, RESP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready: register write/addr/wdata to bus, addr[1:0] forced to 2'b00, trans<=1, go REQ.
- REQ: trans, write, addr, wdata held stable. On posedge with ready===1: trans<=0, rsp_rdata<=write?0:rdata, rsp_err<=0, rsp_valid<=1, go RESP.
- RESP: trans=0, cmd_ready=0; rsp_* held stable until rsp_valid&&rsp_ready, then rsp_valid<=0, go IDLE.
- Single outstanding transfer; no new command accepted until response consumed.
- ready sampled only in REQ; ready in IDLE/RESP ignored.
- rdata/ready X or Z: ready treated as 0 (===1 compare).
- write/addr/wdata keep last values after transfer; only trans qualifies them.

## Timing
- Reset (rstz=0, asynchronous, immediate): state IDLE, trans=0, write=0, addr=0, wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, cmd_ready=0 while rstz=0, 1 from first cycle after release.
- Reset mid-transfer: transfer and pending response dropped, no response issued.
- Command accepted at posedge T: trans high from T; slave with zero wait states asserts ready after T+1; master samples at T+2; rsp_valid high from T+2. Latency cmd accept to rsp_valid = 2 + slave wait states.
- trans low for at least 2 cycles between transfers (RESP cycle + IDLE accept cycle), satisfying slave's post-ready idle cycle.
- rsp_ready held high: back-to-back zero-wait transfers every 4 cycles.

## Configuration
- BUS_MASTER_TIMEOUT_EN defined: counter cleared on entry to REQ, incremented each REQ cycle; when count reaches TIMEOUT with no ready: trans<=0, rsp_err<=1, rsp_rdata<=0, rsp_valid<=1, go RESP. Late ready after abort ignored. ready in the same cycle as count reaching TIMEOUT wins (normal completion).
- Undefined: no counter, REQ waits indefinitely, rsp_err constant 0, TIMEOUT unused.

## Structure
- bus_master_pkg: state enum (IDLE, REQ, RESP), default ADDR_W/DATA_W constants, response struct {rdata, err}.
- Sub-module bus_master_wdog: clear/enable/expired counter, instantiated only under BUS_MASTER_TIMEOUT_EN.

## Test plan
- Write 0x1000 data 0xDEADBEEF then read 0x1000 against slave model -> rsp_rdata=0xDEADBEEF, rsp_err=0.
- Read from addr 0x2003 after writing 0xA5A5_0F0F to 0x2000 -> bus addr=0x2000, rsp_rdata=0xA5A50F0F.
- Slave wait 0..3 random over 200 transfers -> trans/addr/wdata stable until ready, trans low ≥2 cycles between transfers, latency 2..5.
- rsp_ready held 0 for 10 cycles -> rsp_valid/rsp_rdata stable, cmd_ready=0, trans=0 throughout.
- rstz pulsed low while in REQ -> all outputs to reset values immediately, no rsp_valid after release.
- With BUS_MASTER_TIMEOUT_EN, TIMEOUT=16, slave never readies -> rsp_valid with rsp_err=1, rsp_rdata=0 exactly 16 cycles after REQ entry; next command completes normally.
